interval_timer: RTL and testbench

Programmable countdown timer that serves the traffic-light controller's start_timer/interval/expired handshake. It holds the three interval lengths (base, extended, yellow) in seconds and loads the one selected by interval when start_timer arrives. It then counts whole seconds from a clock prescaler and returns a single-cycle expired pulse. It also accepts runtime reprogramming of the three lengths from the synchronized program request.

---
 rtl/interval_timer.sv | 99 +++++++++
 tb/tb_interval_timer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/interval_timer.sv
// Countdown timer for the traffic-light controller: loads one of three
// programmable lengths on start_timer and pulses expired after that many seconds.
module interval_timer #(
  parameter int unsigned CLK_PER_SEC = 50000000,
  parameter int unsigned VAL_W       = 4,
  parameter int unsigned DEF_BASE    = 6,
  parameter int unsigned DEF_EXT     = 3,
  parameter int unsigned DEF_YEL     = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_timer,
  input  logic [1:0]       interval,
  input  logic             prog_sync,
  input  logic [1:0]       time_param_sel,
  input  logic [VAL_W-1:0] time_value,
  output logic             expired,
  output logic             one_hz,
  output logic [VAL_W-1:0] remaining
);

  localparam int unsigned PRE_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;

  typedef enum logic [1:0] {
    SEL_BASE = 2'b00,
    SEL_EXT  = 2'b01,
    SEL_YEL  = 2'b10,
    SEL_NONE = 2'b11
  } sel_e;

  logic [PRE_W-1:0] prescaler;
  logic [VAL_W-1:0] base_len;
  logic [VAL_W-1:0] ext_len;
  logic [VAL_W-1:0] yel_len;
  logic             active;
  logic             tick;
  logic [VAL_W-1:0] prog_value;
  logic [VAL_W-1:0] start_value;
  sel_e             prog_sel;
  sel_e             start_sel;

  assign tick = (prescaler == PRE_W'(CLK_PER_SEC - 1));

  always_comb begin
    prog_value = (time_value == '0) ? VAL_W'(1) : time_value;
    prog_sel   = sel_e'(time_param_sel);
    start_sel  = (interval == 2'b11) ? SEL_BASE : sel_e'(interval);
    case (start_sel)
      SEL_EXT: start_value = ext_len;
      SEL_YEL: start_value = yel_len;
      default: start_value = base_len;
    endcase
    // A write landing on the same edge as the start is visible to that start.
    if (prog_sync && (prog_sel == start_sel)) begin
      start_value = prog_value;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      base_len  <= VAL_W'(DEF_BASE);
      ext_len   <= VAL_W'(DEF_EXT);
      yel_len   <= VAL_W'(DEF_YEL);
      remaining <= '0;
      active    <= 1'b0;
      expired   <= 1'b0;
      one_hz    <= 1'b0;
    end else begin
      one_hz    <= tick;
      expired   <= 1'b0;
      prescaler <= (start_timer || tick) ? '0 : prescaler + PRE_W'(1);

      if (prog_sync) begin
        case (prog_sel)
          SEL_BASE: base_len <= prog_value;
          SEL_EXT:  ext_len  <= prog_value;
          SEL_YEL:  yel_len  <= prog_value;
          default:  ;
        endcase
      end

      if (start_timer) begin
        remaining <= start_value;
        active    <= 1'b1;
      end else if (prog_sync) begin
        remaining <= '0;
        active    <= 1'b0;
      end else if (active && tick) begin
        if (remaining == VAL_W'(1)) begin
          active  <= 1'b0;
          expired <= 1'b1;
        end
        remaining <= remaining - VAL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_interval_timer.sv
// Bench for interval_timer: an edge-count model of the timer checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_interval_timer;

  localparam int C = 4;
  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         start_timer;
  logic [1:0]   interval;
  logic         prog_sync;
  logic [1:0]   time_param_sel;
  logic [W-1:0] time_value;
  logic         expired;
  logic         one_hz;
  logic [W-1:0] remaining;

  always #5 clock = ~clock;

  interval_timer #(
    .CLK_PER_SEC(C),
    .VAL_W      (W),
    .DEF_BASE   (6),
    .DEF_EXT    (3),
    .DEF_YEL    (2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start_timer   (start_timer),
    .interval      (interval),
    .prog_sync     (prog_sync),
    .time_param_sel(time_param_sel),
    .time_value    (time_value),
    .expired       (expired),
    .one_hz        (one_hz),
    .remaining     (remaining)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: counts edges since reset; a second boundary falls every C edges after
  // the last prescaler restart, and a count of V started at edge S ends at S+V*C.
  int m_len[3];
  int m_n, m_origin, m_start, m_v;
  bit m_active;
  int m_exp, m_hz, m_rem;

  always @(posedge clock or posedge reset) begin
    int pv;
    int idx;
    bit tick;
    if (reset) begin
      m_len    = '{6, 3, 2};
      m_n      = 0;
      m_origin = 0;
      m_start  = 0;
      m_v      = 0;
      m_active = 0;
      m_exp    = 0;
      m_hz     = 0;
      m_rem    = 0;
    end else begin
      m_n++;
      tick  = (m_n > m_origin) && (((m_n - m_origin) % C) == 0);
      m_hz  = tick ? 1 : 0;
      m_exp = 0;
      pv    = (time_value == 0) ? 1 : int'(time_value);
      if (prog_sync && time_param_sel != 2'd3) m_len[time_param_sel] = pv;
      if (start_timer) begin
        idx      = (interval == 2'd3) ? 0 : int'(interval);
        m_v      = m_len[idx];
        m_start  = m_n;
        m_origin = m_n;
        m_active = 1;
      end else if (prog_sync) begin
        m_active = 0;
      end else if (m_active && m_n == m_start + m_v * C) begin
        m_active = 0;
        m_exp    = 1;
      end
      m_rem = m_active ? (m_v - (m_n - m_start) / C) : 0;
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      check("expired", 32'(expired), m_exp);
      check("one_hz", 32'(one_hz), m_hz);
      check("remaining", 32'(remaining), m_rem);
    end
  end

  // All stimulus tasks begin and end just after a falling edge.
  task automatic do_start(input int sel);
    start_timer = 1'b1;
    interval    = 2'(sel);
    @(negedge clock);
    start_timer = 1'b0;
  endtask

  task automatic do_prog(input int sel, input int val);
    prog_sync      = 1'b1;
    time_param_sel = 2'(sel);
    time_value     = W'(val);
    @(negedge clock);
    prog_sync = 1'b0;
  endtask

  task automatic wait_expired(output int cycles);
    cycles = 0;
    do begin
      @(negedge clock);
      cycles++;
    end while (!expired && cycles < 200);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    finish_run();
  end

  initial begin
    int cyc;
    int pulses;
    reset          = 1'b1;
    start_timer    = 1'b0;
    interval       = 2'd0;
    prog_sync      = 1'b0;
    time_param_sel = 2'd3;
    time_value     = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("reset_remaining", 32'(remaining), 0);
    check("reset_expired", 32'(expired), 0);
    check("reset_one_hz", 32'(one_hz), 0);

    // Default base interval: 6 s at 4 cycles/s
    do_start(0);
    check("base_load", 32'(remaining), 6);
    wait_expired(cyc);
    check("base_latency", 32'(cyc), 24);
    check("base_remaining_end", 32'(remaining), 0);
    @(negedge clock);
    check("base_pulse_width", 32'(expired), 0);

    do_start(2);
    wait_expired(cyc);
    check("yellow_latency", 32'(cyc), 8);
    do_start(3);
    wait_expired(cyc);
    check("sel11_latency", 32'(cyc), 24);

    do_prog(1, 5);
    do_start(1);
    wait_expired(cyc);
    check("prog_ext_latency", 32'(cyc), 20);
    do_prog(0, 0);
    do_start(0);
    check("coerced_load", 32'(remaining), 1);
    wait_expired(cyc);
    check("coerced_latency", 32'(cyc), 4);

    do_reset();

    // Restart mid-count at E0+10 with the extended interval
    do_start(0);
    repeat (9) @(negedge clock);
    do_start(1);
    wait_expired(cyc);
    check("restart_latency", 32'(cyc), 12);

    // Start on the final-tick edge of a yellow count
    do_start(2);
    repeat (7) @(negedge clock);
    do_start(0);
    check("final_tick_no_pulse", 32'(expired), 0);
    check("final_tick_reload", 32'(remaining), 6);
    wait_expired(cyc);
    check("final_tick_relatency", 32'(cyc), 24);

    // prog_sync with sel=11 aborts the count
    do_start(0);
    repeat (5) @(negedge clock);
    do_prog(3, 7);
    pulses = 0;
    repeat (40) begin
      @(negedge clock);
      if (expired) pulses++;
    end
    check("abort_no_pulse", 32'(pulses), 0);
    check("abort_remaining", 32'(remaining), 0);

    // Asynchronous reset mid-count restores the defaults
    do_prog(2, 9);
    do_prog(1, 5);
    do_start(0);
    repeat (5) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("async_expired", 32'(expired), 0);
    check("async_remaining", 32'(remaining), 0);
    check("async_one_hz", 32'(one_hz), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    do_start(2);
    wait_expired(cyc);
    check("restored_yellow", 32'(cyc), 8);
    do_start(1);
    wait_expired(cyc);
    check("restored_ext", 32'(cyc), 12);

    // Randomized traffic against the model
    repeat (3000) begin
      @(negedge clock);
      start_timer    = ($urandom_range(0, 39) == 0);
      interval       = 2'($urandom_range(0, 3));
      prog_sync      = ($urandom_range(0, 49) == 0);
      time_param_sel = 2'($urandom_range(0, 3));
      time_value     = W'($urandom_range(0, 15));
    end
    @(negedge clock);
    start_timer = 1'b0;
    prog_sync   = 1'b0;
    repeat (10) @(negedge clock);
    finish_run();
  end

endmodule
